fp32_seq_subtractor: RTL

//  Multi-cycle IEEE-754 single-precision subtractor, O = A - B; inverse operation of the combinational fp32 adder.

---
 rtl/fp32_seq_subtractor.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/fp32_seq_subtractor.sv
// fp32 subtractor, one-bit-per-cycle align/normalise FSM.
// Build option: define FP32_SUB_RNE_EN for round-to-nearest-even, else truncation.
module fp32_seq_subtractor #(
  parameter int unsigned ALIGN_LIMIT = 27,
  parameter logic [31:0] QNAN        = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] o,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_SUB,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [7:0] LIM = 8'(ALIGN_LIMIT);

  state_t      state_q, state_d;
  logic [27:0] x_q, y_q;
  logic        sx_q, sy_q;
  logic [8:0]  exp_q;
  logic [7:0]  cnt_q;
  logic        spec_q;
  logic [31:0] o_q;

  logic        accept;
  logic [7:0]  a_exp, b_exp;
  logic [7:0]  ea_w, eb_w;
  logic [27:0] ma_w, mb_w;
  logic        a_big;
  logic [7:0]  diff;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        a_zero, b_zero;
  logic        spec_hit;
  logic [31:0] spec_val;

  logic        add_op, x_ge;
  logic [27:0] sum_c;
  logic        sgn_c;

  logic        inc;
  logic [24:0] rnd;
  logic [8:0]  rexp;
  logic [23:0] rman;
  logic [31:0] res;

  assign accept = in_valid & in_ready;

  assign a_exp  = a[30:23];
  assign b_exp  = b[30:23];
  assign a_nan  = (&a_exp) & (|a[22:0]);
  assign b_nan  = (&b_exp) & (|b[22:0]);
  assign a_inf  = (&a_exp) & ~(|a[22:0]);
  assign b_inf  = (&b_exp) & ~(|b[22:0]);
  assign a_zero = ~(|a[30:0]);
  assign b_zero = ~(|b[30:0]);
  assign ea_w   = (a_exp == 8'd0) ? 8'd1 : a_exp;
  assign eb_w   = (b_exp == 8'd0) ? 8'd1 : b_exp;
  assign ma_w   = {1'b0, |a_exp, a[22:0], 3'b000};
  assign mb_w   = {1'b0, |b_exp, b[22:0], 3'b000};
  assign a_big  = ea_w >= eb_w;
  assign diff   = a_big ? (ea_w - eb_w) : (eb_w - ea_w);

  // Special-operand result, decided from the raw inputs at accept.
  always_comb begin
    spec_hit = 1'b1;
    spec_val = QNAN;
    if (a_nan | b_nan) begin
      spec_val = QNAN;
    end else if (a_inf & b_inf) begin
      spec_val = (a[31] == b[31]) ? QNAN : a;
    end else if (a_inf) begin
      spec_val = a;
    end else if (b_inf) begin
      spec_val = {~b[31], b[30:0]};
    end else if (a_zero & b_zero) begin
      spec_val = {a[31] & ~b[31], 31'd0};
    end else begin
      spec_hit = 1'b0;
      spec_val = 32'd0;
    end
  end

  // Magnitude add or subtract of the aligned operands.
  always_comb begin
    add_op = (sx_q == sy_q);
    x_ge   = (x_q >= y_q);
    if (add_op) begin
      sum_c = x_q + y_q;
      sgn_c = sx_q;
    end else if (x_q == y_q) begin
      sum_c = 28'd0;
      sgn_c = 1'b0;
    end else if (x_ge) begin
      sum_c = x_q - y_q;
      sgn_c = sx_q;
    end else begin
      sum_c = y_q - x_q;
      sgn_c = sy_q;
    end
  end

  // Rounding and packing of the normalised mantissa.
  always_comb begin
`ifdef FP32_SUB_RNE_EN
    inc = x_q[2] & (x_q[1] | x_q[0] | x_q[3]);
`else
    inc = 1'b0;
`endif
    rnd  = {1'b0, x_q[26:3]} + {24'd0, inc};
    rexp = exp_q + {8'd0, rnd[24]};
    rman = rnd[24] ? rnd[24:1] : rnd[23:0];
    res  = {sx_q, rexp[7:0], rman[22:0]};
    if (rman == 24'd0) begin
      res = 32'd0;
    end else if (rexp >= 9'd255) begin
      res = {sx_q, 8'hFF, 23'd0};
    end else if (!rman[23]) begin
      res = {sx_q, 8'd0, rman[22:0]};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; specials leave from the first align cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ALIGN;
      end
      S_ALIGN: begin
        if (spec_q)
          state_d = S_DONE;
        else if (cnt_q > LIM || cnt_q <= 8'd1)
          state_d = S_SUB;
      end
      S_SUB: begin
        if (sum_c == 28'd0)
          state_d = S_ROUND;
        else if (sum_c[27])
          state_d = S_NORM;
        else if (sum_c[26] || exp_q == 9'd1)
          state_d = S_ROUND;
        else
          state_d = S_NORM;
      end
      S_NORM: begin
        if (x_q[27] || x_q[25] || exp_q == 9'd2)
          state_d = S_ROUND;
      end
      S_ROUND: state_d = S_DONE;
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs from state.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
    o         = o_q;
  end

  // Datapath: capture, one-bit align, add/sub, one-bit normalise, round.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= 28'd0;
      y_q    <= 28'd0;
      sx_q   <= 1'b0;
      sy_q   <= 1'b0;
      exp_q  <= 9'd0;
      cnt_q  <= 8'd0;
      spec_q <= 1'b0;
      o_q    <= 32'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            spec_q <= spec_hit;
            if (spec_hit) o_q <= spec_val;
            x_q    <= a_big ? ma_w : mb_w;
            y_q    <= a_big ? mb_w : ma_w;
            sx_q   <= a_big ? a[31] : ~b[31];
            sy_q   <= a_big ? ~b[31] : a[31];
            exp_q  <= {1'b0, a_big ? ea_w : eb_w};
            cnt_q  <= diff;
          end
        end
        S_ALIGN: begin
          if (!spec_q) begin
            if (cnt_q > LIM) begin
              y_q   <= {27'd0, |y_q};
              cnt_q <= 8'd0;
            end else if (cnt_q != 8'd0) begin
              y_q   <= {1'b0, y_q[27:2], |y_q[1:0]};
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        S_SUB: begin
          x_q  <= sum_c;
          sx_q <= sgn_c;
        end
        S_NORM: begin
          if (x_q[27]) begin
            x_q   <= {1'b0, x_q[27:2], |x_q[1:0]};
            exp_q <= exp_q + 9'd1;
          end else begin
            x_q   <= x_q << 1;
            exp_q <= exp_q - 9'd1;
          end
        end
        S_ROUND: o_q <= res;
        default: ;
      endcase
    end
  end

endmodule
